dff: RTL and testbench
======================

DFF -- requirements
Module: dff

Interface
REQ-001 Parameter WIDTH, default 1: bit width of d and q.
REQ-002 Parameter RESET_VALUE, default all zeros (WIDTH bits): value loaded into q by reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge only.
REQ-004 rst  input  1  reset; synchronous, active-high; sampled on the rising edge of clk.
REQ-005 d  input  WIDTH  data to be captured.
REQ-006 q  output  WIDTH  registered data; driven directly from the storage flop, with no combinational path from d or rst.

Function
REQ-007 On each rising clk edge with rst=0, q SHALL take the value of d sampled at that edge.
- Latency is exactly 1 cycle.
- q SHALL be stable between edges.
REQ-008 On each rising clk edge with rst=1, q SHALL take RESET_VALUE, regardless of d.
REQ-009 Reset has priority: if rst=1 and d changes at the same edge, q = RESET_VALUE.
REQ-010 Asserting or deasserting rst between clock edges SHALL NOT change q until the next rising edge.
REQ-011 The first rising edge with rst=0 after reset release SHALL capture d from that edge.
REQ-012 Holding d constant SHALL hold q constant, with no glitches on q.
REQ-013 All WIDTH bits SHALL be captured independently, with no bit reordering or truncation.
REQ-014 Before the first rising edge with rst=1, q is undefined (X in simulation).
- No initial value is assumed in RTL.
- The bench SHALL apply reset before checking q.
REQ-015 There is no enable, no asynchronous path, and no internal state other than the WIDTH-bit register.
REQ-016 The design SHALL be synthesizable and contain no delays or initial blocks.

Reset
REQ-017 Reset is synchronous and active-high.
- rst=1 sampled at a rising clk edge loads q with RESET_VALUE (0 by default).
REQ-018 Reset is level-sensitive per edge: q stays at RESET_VALUE for every edge at which rst remains 1.
REQ-019 Reset asserted mid-operation SHALL override the data path at the next rising edge.
- d captured before that edge is discarded.
REQ-020 The bench SHALL hold rst=1 for at least one rising edge at start-up.
- Bench clock: 10 time-unit period, rst=1 from time 0.
- rst changes away from clock edges to avoid sampling races.

Verification
REQ-021 Reset at start: rst=1 over first edge, d=1 -> q=0 after that edge; q stays 0 while rst=1.
REQ-022 Basic capture, reset released, d sequence 1,0,1,1,0 applied one per cycle -> q equals same sequence delayed by exactly one edge.
REQ-023 Reset priority: rst=1 and d=1 at same edge while q=1 -> q=0 after that edge.
REQ-024 Mid-operation reset:
- Setup: q=1, rst pulsed high for one edge, then low with d=1.
- Required q: 0 for one cycle, then 1.
REQ-025 Between-edge stability: d toggled (0->1->0) between two edges, sampled value 0 -> q remains at previous value until edge, then 0.
REQ-026 Random run (~100 cycles, random d, occasional rst):
- Scoreboard model: q(n+1) = rst(n) ? RESET_VALUE : d(n).
- Zero mismatches required.

Source files
------------

// File: rtl/dff.sv
// dff: WIDTH-bit D flip-flop with a synchronous, active-high reset.
// Ports:
//   clk - clock; all state changes happen on its rising edge
//   rst - synchronous active-high reset; loads RESET_VALUE
//   d   - data captured on each rising edge while rst is low
//   q   - registered data, driven straight from the storage flop
module dff #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Reset wins over data at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= d;
        end
    end

    // No logic between the flop and the port.
    assign q = r_q;

endmodule

// File: tb/tb_dff.sv
// tb_dff: directed and random checks of dff against a reference model.
// Two instances: default (1 bit, reset 0) and 8 bits with reset 8'hA5.
module tb_dff;

    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d1  = 1'b1;
    logic [7:0] d8  = 8'h3C;
    logic       q1;
    logic [7:0] q8;

    int errors = 0;
    int checks = 0;

    // Model state: what each q must show after the most recent edge.
    logic       exp1;
    logic [7:0] exp8;

    always #5 clk = ~clk;

    dff u_dff1 (
        .clk (clk),
        .rst (rst),
        .d   (d1),
        .q   (q1)
    );

    dff #(
        .WIDTH       (8),
        .RESET_VALUE (RV8)
    ) u_dff8 (
        .clk (clk),
        .rst (rst),
        .d   (d8),
        .q   (q8)
    );

    task automatic chk1(input string tag, input logic obs, input logic e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: q1=%b expected %b", tag, obs, e);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: q8=%h expected %h", tag, obs, e);
        end
    endtask

    // Apply inputs at the falling edge, confirm q did not move with them,
    // then check the value captured at the next rising edge.
    task automatic cycle(input string tag, input logic r, input logic dv,
                         input logic [7:0] dw);
        @(negedge clk);
        rst = r;
        d1  = dv;
        d8  = dw;
        #1;
        chk1({tag, "_hold"}, q1, exp1);
        chk8({tag, "_hold"}, q8, exp8);
        @(posedge clk);
        exp1 = r ? 1'b0 : dv;
        exp8 = r ? RV8  : dw;
        #1;
        chk1(tag, q1, exp1);
        chk8(tag, q8, exp8);
    endtask

    initial begin
        logic [4:0] seq;
        logic       r;
        logic       dv;
        logic [7:0] dw;
        seq = 5'b01101;

        // Reset at start: rst=1, d=1 over the first edge.
        @(posedge clk);
        #1;
        exp1 = 1'b0;
        exp8 = RV8;
        chk1("rst_first", q1, exp1);
        chk8("rst_first", q8, exp8);
        cycle("rst_held_a", 1'b1, 1'b1, 8'hFF);
        cycle("rst_held_b", 1'b1, 1'b0, 8'h00);

        // Basic capture of 1,0,1,1,0 plus walking bits on the wide port.
        for (int i = 0; i < 5; i++) begin
            cycle("capture", 1'b0, seq[i], 8'h01 << i);
        end
        cycle("bits_hi", 1'b0, 1'b1, 8'h80);
        cycle("bits_mix", 1'b0, 1'b0, 8'h5A);

        // Reset priority while q=1.
        cycle("pri_setup", 1'b0, 1'b1, 8'hFF);
        cycle("rst_prio", 1'b1, 1'b1, 8'hFF);

        // Mid-operation reset pulse: 0 for one cycle, then 1.
        cycle("mid_setup", 1'b0, 1'b1, 8'h0F);
        cycle("mid_rst", 1'b1, 1'b1, 8'hF0);
        cycle("mid_rel", 1'b0, 1'b1, 8'hC3);

        // d toggles 0->1->0 between edges; q must wait for the edge.
        @(negedge clk);
        d1 = 1'b0;
        d8 = 8'h00;
        #1;
        chk1("tog_a", q1, exp1);
        d1 = 1'b1;
        d8 = 8'hFF;
        #1;
        chk1("tog_b", q1, exp1);
        chk8("tog_b", q8, exp8);
        d1 = 1'b0;
        d8 = 8'h00;
        @(posedge clk);
        #1;
        exp1 = 1'b0;
        exp8 = 8'h00;
        chk1("tog_edge", q1, exp1);
        chk8("tog_edge", q8, exp8);

        // rst asserted between edges must not touch q until the edge.
        cycle("rst_mid_setup", 1'b0, 1'b1, 8'h66);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk1("rst_between", q1, exp1);
        chk8("rst_between", q8, exp8);
        @(posedge clk);
        #1;
        exp1 = 1'b0;
        exp8 = RV8;
        chk1("rst_edge", q1, exp1);
        chk8("rst_edge", q8, exp8);
        // Deassert between edges: q stays at reset value until the edge.
        @(negedge clk);
        rst = 1'b0;
        d1  = 1'b1;
        d8  = 8'h99;
        #2;
        chk1("rel_between", q1, exp1);
        chk8("rel_between", q8, exp8);
        @(posedge clk);
        #1;
        exp1 = 1'b1;
        exp8 = 8'h99;
        chk1("rel_edge", q1, exp1);
        chk8("rel_edge", q8, exp8);

        // Random run: q(n+1) = rst(n) ? RESET_VALUE : d(n).
        for (int n = 0; n < 100; n++) begin
            r  = ($urandom_range(0, 9) == 0);
            dv = 1'($urandom);
            dw = 8'($urandom);
            cycle("random", r, dv, dw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
